// File: rtl/led_panel_tx_if.sv
// Pattern-to-panel link: LED vector and enable in, serial line and frame status out.
interface led_panel_tx_if;
  logic        en;
  logic [5:0]  led;
  logic        tx;
  logic        busy;
  logic [15:0] frame_cnt;

  modport master (output en, led, input tx, busy, frame_cnt);
  modport slave  (input en, led, output tx, busy, frame_cnt);
endinterface

// File: rtl/led_panel_tx.sv
// Serializes the 6-bit LED pattern into 11-bit UART-style frames (start, 8 data, even parity, stop),
// sent on every pattern change and on a periodic refresh.
module led_panel_tx #(
  parameter int unsigned CLK_DIV        = 434,
  parameter int unsigned REFRESH_CYCLES = 50000000,
  parameter logic [1:0]  HDR            = 2'b10
) (
  input  logic           clk,
  input  logic           sysrst,
  led_panel_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [31:0] REF_LAST = 32'(REFRESH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [5:0]  snap_q, snap_d;
  logic [5:0]  last_q, last_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] timer_q, timer_d;
  logic        pend_q, pend_d;

  logic [7:0]  data_byte;
  logic        div_end;
  logic        trigger;
  logic [31:0] timer_inc;

  assign data_byte = {HDR, snap_q};
  assign div_end   = (div_q == DIV_LAST);
  assign trigger   = (state_q == S_IDLE) && bus.en && ((bus.led != last_q) || pend_q);
  assign timer_inc = (timer_q == REF_LAST) ? timer_q : timer_q + 32'd1;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    snap_d  = snap_q;
    last_d  = last_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    pend_d  = pend_q;

    // Refresh timer runs regardless of the line state; a frame start below overrides it.
    if (REFRESH_CYCLES != 0) begin
      timer_d = timer_inc;
      if (timer_inc == REF_LAST) pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          snap_d  = bus.led;
          last_d  = bus.led;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          timer_d = '0;
          pend_d  = 1'b0;
        end
      end
      default: begin
        div_d = div_end ? 16'd0 : div_q + 16'd1;
        if (div_end) begin
          case (state_q)
            S_START: begin
              state_d = S_DATA;
              tx_d    = data_byte[0];
            end
            S_DATA: begin
              if (bit_q == 3'd7) begin
                state_d = S_PARITY;
                tx_d    = ^data_byte;
              end else begin
                bit_d = bit_q + 3'd1;
                tx_d  = data_byte[bit_q + 3'd1];
              end
            end
            S_PARITY: begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
            default: begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              cnt_d   = cnt_q + 16'd1;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (sysrst) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      last_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      timer_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      last_q  <= last_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_led_panel_tx.sv
// Scoreboard bench: expected bytes are queued as stimulus is driven; a line monitor decodes each frame and compares.
module tb_led_panel_tx;

  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, mon_sel;
  led_panel_tx_if if0 ();
  led_panel_tx_if if1 ();

  led_panel_tx #(.CLK_DIV(DIV), .REFRESH_CYCLES(0), .HDR(2'b10)) dut0 (
    .clk(clk), .sysrst(rst0), .bus(if0)
  );
  led_panel_tx #(.CLK_DIV(DIV), .REFRESH_CYCLES(100), .HDR(2'b10)) dut1 (
    .clk(clk), .sysrst(rst1), .bus(if1)
  );

  logic mon_tx, mon_busy;
  assign mon_tx   = mon_sel ? if1.tx   : if0.tx;
  assign mon_busy = mon_sel ? if1.busy : if0.busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sb_q[$];
  int mon_starts[$];
  int mon_frames = 0;
  int mon_aborts = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // Line monitor: samples mid-bit, discards frames cut short by busy dropping.
  initial begin : monitor
    logic       prev;
    logic [10:0] bits;
    logic       aborted;
    logic [7:0] exp_b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_tx === 1'b0 && prev === 1'b1 && mon_busy === 1'b1) begin
        mon_starts.push_back(cyc);
        bits    = '1;
        aborted = 1'b0;
        for (int k = 1; k <= 42; k++) begin
          @(negedge clk);
          if (mon_busy !== 1'b1) aborted = 1'b1;
          if (aborted) break;
          if (k % 4 == 2) bits[k / 4] = mon_tx;
        end
        if (aborted) begin
          mon_aborts++;
        end else begin
          mon_frames++;
          check("mon_q_nonempty", 32'(sb_q.size() != 0), 32'd1);
          exp_b = 8'h00;
          if (sb_q.size() != 0) exp_b = sb_q.pop_front();
          check("mon_start", 32'(bits[0]), 32'd0);
          check("mon_data", 32'(bits[8:1]), 32'(exp_b));
          check("mon_parity", 32'(bits[9]), 32'(^exp_b));
          check("mon_stop", 32'(bits[10]), 32'd1);
        end
      end
      prev = mon_tx;
    end
  end

  task automatic wait_start(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (mon_busy !== 1'b1 && lat < 500);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_tx_start"}, 32'(mon_tx), 32'd0);
  endtask

  task automatic wait_end(input string tag, input int exp_rem);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (mon_busy !== 1'b1 || n >= 2000) break;
      n++;
    end
    check({tag, "_busy_len"}, 32'(n), 32'(exp_rem));
  endtask

  initial begin
    int lows, n, base, fb;
    rst0 = 1'b1;
    rst1 = 1'b1;
    mon_sel = 1'b0;
    if0.en  = 1'b1;
    if0.led = 6'b111110;
    if1.en  = 1'b1;
    if1.led = 6'b000000;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(if0.tx), 32'd1);
    check("rst_busy", 32'(if0.busy), 32'd0);
    check("rst_frame_cnt", 32'(if0.frame_cnt), 32'd0);

    // First frame goes out automatically since last_sent resets to zero.
    sb_q.push_back(8'hBE);
    rst0 = 1'b0;
    wait_start("s1", 1);
    wait_end("s1", 43);
    check("s1_frame_cnt", 32'(if0.frame_cnt), 32'd1);
    repeat (100) @(negedge clk);
    check("s1_no_extra_frames", 32'(mon_frames), 32'd1);
    check("s1_frame_cnt_hold", 32'(if0.frame_cnt), 32'd1);

    if0.led = 6'b000011;
    sb_q.push_back(8'h83);
    wait_start("s2", 1);
    wait_end("s2", 43);
    check("s2_frame_cnt", 32'(if0.frame_cnt), 32'd2);

    // Two mid-frame changes collapse into one follow-up frame with the latest value.
    if0.led = 6'b011000;
    sb_q.push_back(8'h98);
    wait_start("s3a", 1);
    repeat (10) @(negedge clk);
    if0.led = 6'b000001;
    repeat (10) @(negedge clk);
    if0.led = 6'b000111;
    sb_q.push_back(8'h87);
    wait_end("s3a", 23);
    wait_start("s3b", 1);
    wait_end("s3b", 43);
    check("s3_frame_cnt", 32'(if0.frame_cnt), 32'd4);
    repeat (60) @(negedge clk);
    check("s3_frames", 32'(mon_frames), 32'd4);

    if0.en  = 1'b0;
    if0.led = 6'b101010;
    sb_q.push_back(8'hAA);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (if0.tx !== 1'b1 || if0.busy !== 1'b0) lows++;
    end
    check("s5_held_idle", 32'(lows), 32'd0);
    if0.en = 1'b1;
    wait_start("s5", 1);
    wait_end("s5", 43);
    check("s5_frame_cnt", 32'(if0.frame_cnt), 32'd5);

    // Abort during data bit 3 (offsets 16..19 after the trigger).
    if0.led = 6'b111110;
    wait_start("s6a", 1);
    repeat (17) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    check("s6_abort_tx", 32'(if0.tx), 32'd1);
    check("s6_abort_busy", 32'(if0.busy), 32'd0);
    check("s6_abort_frame_cnt", 32'(if0.frame_cnt), 32'd0);
    sb_q.push_back(8'hBE);
    rst0 = 1'b0;
    wait_start("s6b", 1);
    wait_end("s6b", 43);
    check("s6_frame_cnt", 32'(if0.frame_cnt), 32'd1);

    // Refresh: constant pattern repeats every 100 cycles.
    mon_sel = 1'b1;
    if1.led = 6'b010101;
    repeat (4) sb_q.push_back(8'h95);
    base = mon_starts.size();
    fb   = mon_frames;
    rst1 = 1'b0;
    wait_start("s4", 1);
    wait_end("s4", 43);
    n = 0;
    while (mon_frames < fb + 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("s4_frames", 32'(mon_frames), 32'(fb + 4));
    repeat (10) @(negedge clk);
    check("s4_frame_cnt", 32'(if1.frame_cnt), 32'd4);
    rst1 = 1'b1;
    check("s4_starts", 32'(mon_starts.size()), 32'(base + 4));
    if (mon_starts.size() >= base + 4) begin
      for (int i = 1; i < 4; i++)
        check("s4_refresh_period", 32'(mon_starts[base + i] - mon_starts[base + i - 1]), 32'd100);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("total_frames", 32'(mon_frames), 32'd10);
    check("aborted_frames", 32'(mon_aborts), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
